// File: rtl/seg_scan_controller.sv
// Three-digit common-anode seven-segment scanner. It provides per-slot blanking, 8-level PWM and leading-zero
// suppression, and latches new values through valid/ready so that each value change lands on a frame boundary.
module seg_scan_controller #(
    parameter int DWELL_CYCLES = 32768,
    parameter int BLANK_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        upd_valid,
    input  logic [11:0] upd_value,
    output logic        upd_ready,
    input  logic [2:0]  bright,
    input  logic        blank_lead_zero,
    output logic [2:0]  anodes,
    output logic [7:0]  cathodes,
    output logic [1:0]  digit_idx,
    output logic        frame_pulse
);
    localparam int CW   = $clog2(DWELL_CYCLES);
    localparam int CW1  = CW + 1;
    localparam int UNIT = (DWELL_CYCLES - BLANK_CYCLES) / 8;

    typedef enum logic [1:0] {PH_BLANK, PH_ON, PH_OFF} phase_t;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    digit_idx_q, digit_idx_d;
    logic [11:0]   disp_val_q, disp_val_d;
    logic [11:0]   pend_q, pend_d;
    logic          pend_full_q, pend_full_d;
    logic [2:0]    bright_s_q, bright_s_d;
    logic          lz_s_q, lz_s_d;
    phase_t        phase_q, phase_d;
    logic [2:0]    anodes_q, anodes_d;
    logic [7:0]    cathodes_q, cathodes_d;

    logic          slot_start, slot_end, frame_end, blank_last, on_last, suppress;
    logic [2:0]    bright_eff;
    logic          lz_eff;
    logic [CW1-1:0] on_last_cnt;
    logic [7:0]    seg_dig [3];

    function automatic logic [7:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 8'hC0;  4'h1: seg7 = 8'hF9;  4'h2: seg7 = 8'hA4;  4'h3: seg7 = 8'hB0;
            4'h4: seg7 = 8'h99;  4'h5: seg7 = 8'h92;  4'h6: seg7 = 8'h82;  4'h7: seg7 = 8'hF8;
            4'h8: seg7 = 8'h80;  4'h9: seg7 = 8'h90;  4'hA: seg7 = 8'h88;  4'hB: seg7 = 8'h83;
            4'hC: seg7 = 8'hC6;  4'hD: seg7 = 8'hA1;  4'hE: seg7 = 8'h86;  default: seg7 = 8'h8E;
        endcase
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_seg
        assign seg_dig[gi] = seg7(disp_val_q[4*gi +: 4]);
    end

    assign upd_ready   = reset & ~pend_full_q;
    assign frame_pulse = frame_end;
    assign anodes      = anodes_q;
    assign cathodes    = cathodes_q;
    assign digit_idx   = digit_idx_q;

    always_comb begin
        slot_start  = (cnt_q == '0);
        slot_end    = (cnt_q == CW'(DWELL_CYCLES - 1));
        frame_end   = slot_end && (digit_idx_q == 2'd2);
        // The first cycle of a slot uses the live inputs so that a one-cycle blank interval still works
        bright_eff  = slot_start ? bright : bright_s_q;
        lz_eff      = slot_start ? blank_lead_zero : lz_s_q;
        on_last_cnt = CW1'(BLANK_CYCLES - 1) + CW1'(UNIT) * (CW1'(bright_eff) + CW1'(1));
        blank_last  = ({1'b0, cnt_q} == CW1'(BLANK_CYCLES - 1));
        on_last     = ({1'b0, cnt_q} == on_last_cnt);
        suppress    = lz_eff && (((digit_idx_q == 2'd2) && (disp_val_q[11:8] == 4'h0)) ||
                                 ((digit_idx_q == 2'd1) && (disp_val_q[11:4] == 8'h00)));

        cnt_d       = slot_end ? '0 : cnt_q + CW'(1);
        digit_idx_d = digit_idx_q;
        if (slot_end) digit_idx_d = (digit_idx_q == 2'd2) ? 2'd0 : digit_idx_q + 2'd1;
        bright_s_d  = bright_eff;
        lz_s_d      = lz_eff;

        phase_d = phase_q;
        case (phase_q)
            PH_BLANK: if (blank_last && !suppress) phase_d = PH_ON;
            PH_ON:    if (on_last) phase_d = PH_OFF;
            PH_OFF:   phase_d = PH_OFF;
            default:  phase_d = PH_BLANK;
        endcase
        if (slot_end) phase_d = PH_BLANK;

        // Drive pins from the next phase so they switch on the same edge as the phase does
        anodes_d   = 3'b111;
        cathodes_d = 8'hFF;
        if (phase_d == PH_ON) begin
            anodes_d = ~(3'b001 << digit_idx_q);
            case (digit_idx_q)
                2'd0:    cathodes_d = seg_dig[0];
                2'd1:    cathodes_d = seg_dig[1];
                default: cathodes_d = seg_dig[2];
            endcase
        end

        disp_val_d  = disp_val_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        if (frame_end && pend_full_q) begin
            disp_val_d  = pend_q;
            pend_full_d = 1'b0;
        end
        if (upd_valid && upd_ready) begin
            pend_d      = upd_value;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q       <= '0;
            digit_idx_q <= 2'd0;
            disp_val_q  <= 12'h000;
            pend_q      <= 12'h000;
            pend_full_q <= 1'b0;
            bright_s_q  <= 3'd0;
            lz_s_q      <= 1'b0;
            phase_q     <= PH_BLANK;
            anodes_q    <= 3'b111;
            cathodes_q  <= 8'hFF;
        end else begin
            cnt_q       <= cnt_d;
            digit_idx_q <= digit_idx_d;
            disp_val_q  <= disp_val_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            bright_s_q  <= bright_s_d;
            lz_s_q      <= lz_s_d;
            phase_q     <= phase_d;
            anodes_q    <= anodes_d;
            cathodes_q  <= cathodes_d;
        end
    end
endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
Sequences the 3-digit common-anode seven-segment display that shows the 12-bit counter value. Time-multiplexes the digits with a per-digit dwell timer and an anti-ghosting blank interval. Applies 8-level PWM brightness and optional leading-zero suppression. Accepts new display values through a valid/ready handshake and applies them only at frame boundaries, so a frame never shows digits from two different values.

Parameters:
DWELL_CYCLES, 32768, clk cycles per digit slot; (DWELL_CYCLES-BLANK_CYCLES) must be a multiple of 8 and at least 8
BLANK_CYCLES, 256, cycles at the start of each slot with all anodes off; must be at least 1

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
upd_valid  input  1  upd_value is offered
upd_value  input  12  new value; [11:8] digit2, [7:4] digit1, [3:0] digit0
upd_ready  output  1  pending slot is free; transfer occurs when upd_valid & upd_ready
bright  input  3  brightness 0..7; sampled on the first cycle of each slot
blank_lead_zero  input  1  suppresses leading zero digits
anodes  output  3  active-low digit enables; bit0 is digit0
cathodes  output  8  active-low segments {dp,g,f,e,d,c,b,a}
digit_idx  output  2  digit currently being scanned (0..2)
frame_pulse  output  1  one-cycle pulse on the last cycle of the digit2 slot

Behaviour:
- Reset (reset=0 at a clk edge): anodes=3'b111, cathodes=8'hFF, digit_idx=0, slot counter=0, disp_val=0, pending empty, frame_pulse=0. Any pending update is discarded. upd_ready=0 while reset=0.
- Reset release: the slot counter counts 0..DWELL_CYCLES-1 per slot. Count 0 is the first cycle with reset=1. After the last count, digit_idx advances 0->1->2->0.
- Per-slot FSM, driven by slot counter cnt:
  - BLANK: cnt < BLANK_CYCLES.
  - ON: the next on_len cycles, where on_len = ((DWELL_CYCLES-BLANK_CYCLES)>>3)*(bright_s+1) and bright_s is bright sampled at cnt=0.
  - OFF: the remainder of the slot. OFF is skipped when bright_s=7.
- anodes/cathodes are registers that change on the same edge as the phase change.
  - BLANK and OFF: anodes=3'b111, cathodes=8'hFF.
  - ON: anodes has only bit digit_idx low; cathodes=seg(nibble of disp_val for digit_idx).
- Segment map, dp always 1: 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E.
- Leading-zero suppression, when blank_lead_zero=1 (sampled per slot):
  - digit2 is suppressed if disp_val[11:8]==0.
  - digit1 is suppressed if disp_val[11:4]==0.
  - digit0 is never suppressed.
  - A suppressed digit behaves as BLANK for its whole slot.
- Update handshake:
  - upd_ready = reset & !pend_full (combinational).
  - Accept: upd_value is latched into pend, and pend_full is set.
  - At the frame boundary (digit_idx=2, cnt=DWELL_CYCLES-1): if pend_full, disp_val<=pend and pend_full is cleared on that edge. The new value is therefore shown starting with the digit0 slot.
  - An accept in the boundary cycle (pending was empty) goes to pend and is shown one frame later.
  - Multiple valids while full are back-pressured; no drops, no overwrite.
- frame_pulse is high exactly in the boundary cycle.
- The bright or blank_lead_zero inputs may change mid-slot; the change has no effect until the next slot starts.

Test Plan:
(Use DWELL_CYCLES=64, BLANK_CYCLES=8, so the ON unit is 7 cycles.)
- Reset, then idle with bright=7:
  - cnt 0..7: anodes=111.
  - cnt 8..63: anodes=110, cathodes=C0.
  - digit1 and digit2 then follow in turn.
  - frame_pulse fires at cycle 191 and every 192 cycles after.
- bright=0, value 0x123:
  - Each slot: 8 blank, 7 ON, 49 OFF cycles.
  - Digit0 ON shows B0 with anodes=110; digit1 ON shows A4 with 101; digit2 ON shows F9 with 011.
- Tearing check:
  - Offer 0xABC mid-digit1: accepted at once, and displayed values are unchanged until frame_pulse.
  - The next digit0 slot shows C6.
- Back-pressure:
  - Offer 0x111 mid-frame, then hold upd_valid with 0x222.
  - upd_ready=0 until the boundary edge and 1 immediately after.
  - 0x222 is accepted then and displayed one frame later.
- Leading-zero suppression with value 0x005 and blank_lead_zero=1:
  - Digit1 and digit2 slots have anodes=111 throughout.
  - Digit0 shows 92.
  - With blank_lead_zero=0, digit1 and digit2 show C0.
- Reset mid-ON of digit1 with pend_full:
  - On the next edge anodes=111, cathodes=FF, digit_idx=0, disp_val=0, and upd_ready=0.
  - After release, upd_ready=1 and the old pend is never displayed.
